// File: rtl/prog_tt_pkg.sv
// Shared types and constants for the programmable truth-table unit.
package prog_tt_pkg;

  typedef enum logic {RUN, LOAD} state_e;

  localparam int unsigned HIT_CNT_W = 16;

  function automatic int unsigned tt_bits(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_serial_loader.sv
// Serial truth-table loader: shadow shift register, bit counter and commit strobe.
module tt_serial_loader #(
  parameter int unsigned TtBits = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_valid,
  input  logic              cfg_bit,
  input  logic              active,
  output logic              commit,
  output logic [TtBits-1:0] tt_word
);

  localparam int unsigned CntW = (TtBits > 2) ? $clog2(TtBits) : 1;

  logic [TtBits-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              unused_lsb;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    // A start always wins over a same-cycle bit, discarding any partial load.
    if (cfg_start) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (active && cfg_valid) begin
      shadow_d = {cfg_bit, shadow_q[TtBits-1:1]};
      if (cnt_q == CntW'(TtBits - 1)) begin
        commit = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  // The committed word includes the bit arriving on the commit edge.
  assign tt_word    = shadow_d;
  assign unused_lsb = shadow_q[0];

endmodule

// File: rtl/prog_truth_table.sv
// Programmable N-input Boolean function with serial reload and registered lookups.
// Optional hit counter enabled by defining HIT_COUNT_EN.
module prog_truth_table
  import prog_tt_pkg::*;
#(
  parameter int unsigned                    N_IN       = 3,
  parameter logic [tt_bits(N_IN)-1:0]       DEFAULT_TT = 'h46
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_IN-1:0]      x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 z,
  output logic [HIT_CNT_W-1:0] hit_cnt
);

  localparam int unsigned TT_BITS = tt_bits(N_IN);

  state_e             state_q, state_d;
  logic [TT_BITS-1:0] tt_q, tt_d;
  logic [TT_BITS-1:0] new_tt;
  logic               commit;
  logic               accept;
  logic               z_q, z_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q;

  tt_serial_loader #(
    .TtBits (TT_BITS)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .active    (state_q == LOAD),
    .commit    (commit),
    .tt_word   (new_tt)
  );

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    tt_d        = tt_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      RUN:  if (cfg_start) state_d = LOAD;
      LOAD: if (!cfg_start && commit) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (commit) tt_d = new_tt;
    // Lookups only happen in RUN, so they always see the table before any commit.
    if (accept) begin
      z_d         = tt_q[x];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      tt_q        <= DEFAULT_TT;
      z_q         <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tt_q        <= tt_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      done_q      <= commit;
    end
  end

  assign z         = z_q;
  assign out_valid = out_valid_q;
  assign cfg_busy  = (state_q == LOAD);
  assign cfg_done  = done_q;

`ifdef HIT_COUNT_EN
  logic [HIT_CNT_W-1:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    if (out_valid_q && out_ready && z_q && (hit_q != '1)) hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= hit_d;
  end

  assign hit_cnt = hit_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_prog_truth_table.sv
// Scoreboard bench for prog_truth_table (N_IN=3, DEFAULT_TT=8'h46).
module tb_prog_truth_table;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic        cfg_busy, cfg_done;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  x = '0;
  logic        out_valid, out_ready = 1'b1, z;
  logic [15:0] hit_cnt;

  logic [7:0]  tt_model;
  logic        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          n_out = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  prog_truth_table #(
    .N_IN       (3),
    .DEFAULT_TT (8'h46)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .hit_cnt   (hit_cnt)
  );

  // Output monitor: inputs only change just after posedge, so negedge sees the coming handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_done) done_cnt++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got z=%0b with empty scoreboard", z);
        end else begin
          logic e;
          e = sb.pop_front();
          n_out++;
          if (z !== e) begin
            errors++;
            $display("FAIL lookup_z: got %0b expected %0b", z, e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    tt_model = 8'h46;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] xv);
    int n = 0;
    in_valid = 1'b1;
    x = xv;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b expected 1 for x=%0d", in_ready, xv);
    end else begin
      sb.push_back(tt_model[xv]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
  endtask

  task automatic load(input logic [7:0] v);
    int d0;
    d0 = done_cnt;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit = v[i];
      checks++;
      if (cfg_busy !== 1'b1) begin
        errors++;
        $display("FAIL load_busy: bit %0d cfg_busy=%0b expected 1", i, cfg_busy);
      end
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    checks++;
    if (cfg_done !== 1'b1 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL load_commit: done=%0b busy=%0b expected 1 0", cfg_done, cfg_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (cfg_done !== 1'b0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL load_done_pulse: done=%0b pulses=%0d expected 0 1", cfg_done, done_cnt - d0);
    end
    tt_model = v;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (z !== 1'b0 || out_valid !== 1'b0 || cfg_busy !== 1'b0 || cfg_done !== 1'b0 ||
        hit_cnt !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: z=%0b ov=%0b busy=%0b done=%0b hit=%0h rdy=%0b expected 0 0 0 0 0 1",
               z, out_valid, cfg_busy, cfg_done, hit_cnt, in_ready);
    end
  endtask

  task automatic test_lookup();
    int n0;
    logic [2:0] xs [5] = '{3'd1, 3'd2, 3'd6, 3'd0, 3'd7};
    n0 = n_out;
    out_ready = 1'b1;
    foreach (xs[i]) send(xs[i]);
    wait_drain();
    checks++;
    if (n_out - n0 != 5) begin
      errors++;
      $display("FAIL lookup_count: got %0d results expected 5", n_out - n0);
    end
  endtask

  task automatic test_load();
    load(8'h80);
    send(3'd7);
    send(3'd1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic zh;
    out_ready = 1'b0;
    send(3'd7);
    in_valid = 1'b1;
    x = 3'd1;
    @(posedge clk); #1;
    zh = tt_model[7];
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || z !== zh) begin
        errors++;
        $display("FAIL backpressure_hold: rdy=%0b ov=%0b z=%0b expected 0 1 %0b",
                 in_ready, out_valid, z, zh);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(3'd1);
    wait_drain();
  endtask

  task automatic test_abort();
    int d0;
    logic [4:0] part = 5'b10101;
    d0 = done_cnt;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_bit = part[i];
      @(posedge clk); #1;
    end
    // Restart with a same-cycle zero bit that must be dropped.
    cfg_valid = 1'b1; cfg_bit = 1'b0;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: pulses=%0d busy=%0b expected 1 0", done_cnt - d0, cfg_busy);
    end
    tt_model = 8'hFF;
    for (int i = 0; i < 8; i++) send(3'(i));
    wait_drain();
  endtask

  task automatic test_reset_mid_load();
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: busy=%0b done=%0b expected 0 0", cfg_busy, cfg_done);
    end
    do_reset();
    send(3'd2);
    send(3'd7);
    wait_drain();
  endtask

  task automatic test_hit_count();
    logic [2:0] xs [10] = '{3'd1, 3'd2, 3'd6, 3'd1, 3'd2, 3'd6, 3'd0, 3'd3, 3'd4, 3'd5};
    logic [15:0] exp_hits;
`ifdef HIT_COUNT_EN
    exp_hits = 16'd6;
`else
    exp_hits = 16'd0;
`endif
    do_reset();
    foreach (xs[i]) send(xs[i]);
    wait_drain();
    checks++;
    if (hit_cnt !== exp_hits) begin
      errors++;
      $display("FAIL hit_cnt: got %0d expected %0d", hit_cnt, exp_hits);
    end
  endtask

  initial begin
    tt_model = 8'h46;
    test_reset();
    test_lookup();
    test_load();
    test_backpressure();
    test_abort();
    test_reset_mid_load();
    test_hit_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
